// File: rtl/conv_unit_fixed_stream.sv
// Streaming fixed-point convolution pixel: dot product of a D*F*F patch and filter plus bias,
// LANES multiply-accumulates per cycle, then round, optional ReLU and saturate.
module conv_unit_fixed_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned D          = 2,
  parameter int unsigned F          = 3,
  parameter int unsigned LANES      = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [D*F*F*DATA_WIDTH-1:0]    image,
  input  logic [D*F*F*DATA_WIDTH-1:0]    filter,
  input  logic [DATA_WIDTH-1:0]          bias,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          result,
  output logic                           busy
);

  localparam int unsigned N      = D * F * F;
  localparam int unsigned STEPS  = N / LANES;
  localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(N) + 2;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned VEC_W  = N * DATA_WIDTH;
  localparam int unsigned SHIFT  = LANES * DATA_WIDTH;

  localparam logic signed [ACC_W-1:0] HALF    = (ACC_W'(1) << FRAC) >> 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_WIDTH - 1));
  localparam logic [STEP_W-1:0]       LAST    = STEP_W'(STEPS - 1);

  if (LANES == 0 || (N % LANES) != 0) begin : g_lanes_check
    $error("LANES must divide D*F*F");
  end

  typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

  state_e                  state_q, state_d;
  logic [VEC_W-1:0]        img_q, img_d;
  logic [VEC_W-1:0]        flt_q, flt_d;
  logic [DATA_WIDTH-1:0]   bias_q, bias_d;
  logic                    relu_q, relu_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;

  logic signed [DATA_WIDTH-1:0] op_a [LANES];
  logic signed [DATA_WIDTH-1:0] op_b [LANES];
  logic signed [PROD_W-1:0]     prod [LANES];
  logic signed [ACC_W-1:0]      lane_sum;
  logic signed [ACC_W-1:0]      round_v;
  logic [DATA_WIDTH-1:0]        sat_v;

  // Captured operands shift down by LANES elements per step, so lanes always read the low slots.
  always_comb begin
    lane_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      op_a[l]  = $signed(img_q[l*DATA_WIDTH +: DATA_WIDTH]);
      op_b[l]  = $signed(flt_q[l*DATA_WIDTH +: DATA_WIDTH]);
      prod[l]  = PROD_W'(op_a[l]) * PROD_W'(op_b[l]);
      lane_sum = lane_sum + ACC_W'(prod[l]);
    end
  end

  // Bias aligned to the product scale, round half toward +inf, back to FRAC fraction bits.
  always_comb begin
    round_v = acc_q + (ACC_W'($signed(bias_q)) <<< FRAC) + HALF;
    round_v = round_v >>> FRAC;
    if (relu_q && round_v[ACC_W-1]) begin
      round_v = '0;
    end
    if (round_v > SAT_MAX) begin
      sat_v = SAT_MAX[DATA_WIDTH-1:0];
    end else if (round_v < SAT_MIN) begin
      sat_v = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_v = round_v[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    img_d    = img_q;
    flt_d    = flt_q;
    bias_d   = bias_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          img_d   = image;
          flt_d   = filter;
          bias_d  = bias;
          relu_d  = relu_en;
          acc_d   = '0;
          step_d  = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d  = acc_q + lane_sum;
        img_d  = img_q >> SHIFT;
        flt_d  = flt_q >> SHIFT;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST) begin
          state_d = StRound;
        end
      end
      StRound: begin
        result_d = sat_v;
        state_d  = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      img_q    <= '0;
      flt_q    <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      flt_q    <= flt_d;
      bias_q   <= bias_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign result    = result_q;

endmodule

// File: tb/tb_conv_unit_fixed_stream.sv
// Bench for conv_unit_fixed_stream: three instances (LANES 3, 1, 18) driven one at a time,
// expected pixels queued at acceptance and compared when the result is handed off.
module tb_conv_unit_fixed_stream;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int N    = 18;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] image;
  logic [N*DW-1:0] filter;
  logic [DW-1:0]   bias;
  logic            relu_en;

  logic          in_valid_s  [3];
  logic          in_ready_s  [3];
  logic          out_valid_s [3];
  logic          out_ready_s [3];
  logic [DW-1:0] result_s    [3];
  logic          busy_s      [3];

  int lat_tab [3] = '{7, 19, 2};
  int exp_q [$];
  int checks = 0;
  int errors = 0;

  conv_unit_fixed_stream #(
    .DATA_WIDTH(DW), .FRAC(FRAC), .D(2), .F(3), .LANES(3)
  ) u_dut_l3 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .image(image), .filter(filter), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .result(result_s[0]),
    .busy(busy_s[0])
  );

  conv_unit_fixed_stream #(
    .DATA_WIDTH(DW), .FRAC(FRAC), .D(2), .F(3), .LANES(1)
  ) u_dut_l1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .image(image), .filter(filter), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .result(result_s[1]),
    .busy(busy_s[1])
  );

  conv_unit_fixed_stream #(
    .DATA_WIDTH(DW), .FRAC(FRAC), .D(2), .F(3), .LANES(18)
  ) u_dut_l18 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .image(image), .filter(filter), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .result(result_s[2]),
    .busy(busy_s[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model(input logic [N*DW-1:0] im, input logic [N*DW-1:0] fl,
                               input logic [DW-1:0] b, input logic relu);
    longint acc;
    longint v;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      acc += longint'($signed(im[k*DW +: DW])) * longint'($signed(fl[k*DW +: DW]));
    end
    v = acc + (longint'($signed(b)) <<< FRAC) + (longint'(1) <<< (FRAC - 1));
    v = v >>> FRAC;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return int'(v & 64'hFFFF);
  endfunction

  task automatic fill(input logic [DW-1:0] iw, input logic [DW-1:0] fw,
                      input logic [DW-1:0] b, input logic r);
    for (int k = 0; k < N; k++) begin
      image[k*DW +: DW]  = iw;
      filter[k*DW +: DW] = fw;
    end
    bias    = b;
    relu_en = r;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      image[k*DW +: DW]  = DW'($urandom_range(0, 2047) - 1024);
      filter[k*DW +: DW] = DW'($urandom_range(0, 2047) - 1024);
    end
    bias    = DW'($urandom_range(0, 4095) - 2048);
    relu_en = 1'($urandom_range(0, 1));
  endtask

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      image[k*DW +: DW]  = DW'($urandom);
      filter[k*DW +: DW] = DW'($urandom);
    end
    bias    = DW'($urandom);
    relu_en = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input int d, input int expv);
    in_valid_s[d] = 1'b1;
    check_eq("accept_ready", int'(in_ready_s[d]), 1);
    @(posedge clk);
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid_s[d] = 1'b0;
  endtask

  task automatic wait_result(input int d, input int hold, input bit offer);
    int            k;
    bit            bad;
    int            expv;
    logic [DW-1:0] r0;
    k   = 0;
    bad = 1'b0;
    out_ready_s[d] = (hold == 0);
    while (!out_valid_s[d] && k < 200) begin
      if (!busy_s[d] || in_ready_s[d]) bad = 1'b1;
      scramble();
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check_eq("latency", k, lat_tab[d]);
    check_eq("busy_during_job", int'(bad), 0);
    if (!out_valid_s[d]) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_ready_s[d] = 1'b1;
      return;
    end
    expv = exp_q.pop_front();
    check_eq("result", int'(result_s[d]), expv);
    r0  = result_s[d];
    bad = 1'b0;
    if (offer) in_valid_s[d] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (result_s[d] !== r0 || !out_valid_s[d] || in_ready_s[d] || !busy_s[d]) bad = 1'b1;
    end
    if (hold > 0) check_eq("hold_stable", int'(bad), 0);
    out_ready_s[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("handoff_valid", int'(out_valid_s[d]), 0);
    check_eq("handoff_ready", int'(in_ready_s[d]), 1);
    check_eq("handoff_busy", int'(busy_s[d]), 0);
    check_eq("result_kept", int'(result_s[d]), int'(r0));
  endtask

  task automatic run_job(input int d, input int expv);
    accept(d, expv);
    wait_result(d, 0, 1'b0);
  endtask

  task automatic backpressure(input int d);
    fill(16'h0100, 16'h0200, 16'h0000, 1'b0);
    accept(d, 16'h2400);
    wait_result(d, 10, 1'b1);
    fill(16'h0100, 16'h0200, 16'h0080, 1'b0);
    accept(d, 16'h2480);
    wait_result(d, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
    end
    fill(16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", int'(in_ready_s[0]), 1);
    check_eq("rst_out_valid", int'(out_valid_s[0]), 0);
    check_eq("rst_result", int'(result_s[0]), 0);
    check_eq("rst_busy", int'(busy_s[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, saturation, ReLU, bias, negative, rounding on the LANES=3 instance
    fill(16'h0100, 16'h0200, 16'h0000, 1'b0); run_job(0, 16'h2400);
    fill(16'h0400, 16'h0400, 16'h0000, 1'b0); run_job(0, 16'h7FFF);
    fill(16'h0400, 16'hFC00, 16'h0000, 1'b0); run_job(0, 16'h8000);
    fill(16'h0400, 16'hFC00, 16'h0000, 1'b1); run_job(0, 16'h0000);
    fill(16'h0100, 16'h0200, 16'h0080, 1'b0); run_job(0, 16'h2480);
    fill(16'h0100, 16'hFF00, 16'h0000, 1'b0); run_job(0, 16'hEE00);
    fill(16'h0000, 16'h0000, 16'h0000, 1'b0);
    image[0 +: DW] = 16'h0001; filter[0 +: DW] = 16'h0080; run_job(0, 16'h0001);
    fill(16'h0000, 16'h0000, 16'h0000, 1'b0);
    image[0 +: DW] = 16'h0001; filter[0 +: DW] = 16'hFF80; run_job(0, 16'h0000);
    fill(16'h0100, 16'hFF00, 16'h0000, 1'b1); run_job(0, 16'h0000);
    fill(16'h0100, 16'hFF00, 16'h0000, 1'b0); run_job(0, 16'hEE00);

    backpressure(0);

    // Abort mid-MAC: everything drops at once, next job starts clean
    fill(16'h0100, 16'h0200, 16'h0000, 1'b0);
    accept(0, 16'h2400);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", int'(out_valid_s[0]), 0);
    check_eq("abort_result", int'(result_s[0]), 0);
    check_eq("abort_busy", int'(busy_s[0]), 0);
    check_eq("abort_in_ready", int'(in_ready_s[0]), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(16'h0100, 16'hFF00, 16'h0000, 1'b0); run_job(0, 16'hEE00);

    for (int d = 1; d < 3; d++) begin
      fill(16'h0100, 16'h0200, 16'h0000, 1'b0); run_job(d, 16'h2400);
      fill(16'h0400, 16'hFC00, 16'h0000, 1'b0); run_job(d, 16'h8000);
      backpressure(d);
    end

    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 4; j++) begin
        fill_random();
        run_job(d, model(image, filter, bias, relu_en));
      end
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_unit_fixed_stream.md
Name: conv_unit_fixed_stream

Overview:
- Parametrised successor to the float dot-product convolution unit. Computes one output pixel: the signed fixed-point dot product of a D×F×F image patch and a D×F×F filter, plus bias, with optional ReLU and saturation.
- Consumes LANES products per cycle, so throughput is selectable.
- valid/ready handshakes on input and output let it sit directly in the conv layer's streaming datapath with backpressure.

Parameters:
- DATA_WIDTH, 16: element width, signed two's complement.
- FRAC, 8: fractional bits of every element, bias and result (Q(DATA_WIDTH-FRAC).FRAC).
- D, 2: input channel count.
- F, 3: filter side length.
- LANES, 3: multipliers used per cycle. Must divide N = D*F*F; elaboration-time error otherwise.

Ports:
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- in_valid  in  1: image/filter/bias/relu_en valid.
- in_ready  out  1: unit can accept a job.
- image  in  N*DATA_WIDTH: element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- filter  in  N*DATA_WIDTH: same layout as image.
- bias  in  DATA_WIDTH: added to the dot product.
- relu_en  in  1: clamp negative results to 0.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts result.
- result  out  DATA_WIDTH: saturated output pixel.
- busy  out  1: high in any state except IDLE.

Behaviour:
- Derived constants: N = D*F*F; STEPS = N/LANES. Accumulator width ACC_W = 2*DATA_WIDTH + clog2(N) + 2, so it never overflows.
- Reset (reset = 0, asynchronous):
  - state goes to IDLE;
  - in_ready = 1, out_valid = 0, result = 0, busy = 0;
  - accumulator, step counter and captured operands are cleared.
  - Reset mid-job abandons the job. No result is produced.
- IDLE:
  - in_ready = 1 (combinational from state).
  - When in_valid & in_ready are high at a clock edge, capture image, filter, bias and relu_en; clear the accumulator and step counter; go to MAC.
- MAC:
  - On each edge, add the sum of the LANES full-precision signed products (2*DATA_WIDTH bits each, sign-extended) for elements step*LANES .. step*LANES+LANES-1 into the accumulator; increment step.
  - After STEPS edges, go to ROUND.
  - Input changes during MAC have no effect, because operands are captured.
- ROUND (one edge):
  - v = acc + (sign-extended bias <<< FRAC).
  - If FRAC > 0, v = v + (1 << (FRAC-1)). This rounds half toward +inf.
  - v = v >>> FRAC (arithmetic shift).
  - If relu_en and v < 0, v = 0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register v into result, set out_valid = 1, go to OUT.
- OUT:
  - result and out_valid are held stable while out_ready = 0.
  - On an edge with out_ready = 1: out_valid goes to 0 and state goes to IDLE. result keeps its last value.
  - in_ready = 0 in OUT. A new job can be accepted on the cycle after the handoff at the earliest.
- Latency: out_valid rises STEPS+1 clock edges after the accepting edge. Minimum job period is STEPS+3 cycles.
- in_valid is ignored when in_ready = 0, and the unit does not drop a job it has already accepted.
- relu_en only affects the job it was captured with.

Test Plan:
1. Defaults (STEPS = 6), all image 0x0100 (1.0), all filter 0x0200 (2.0), bias 0, relu_en 0, out_ready 1 → out_valid rises exactly 7 edges after acceptance, result = 0x2400 (36.0), busy high for the whole job.
2. All elements 0x0400 (4.0) in both operands → true sum 288.0 saturates, result = 0x7FFF. Repeat with filter 0xFC00 (-4.0) → result = 0x8000. Repeat with relu_en = 1 → result = 0x0000.
3. Case 1 with bias 0x0080 (0.5) → result = 0x2480. Image 0x0100, filter 0xFF00 (-1.0), bias 0 → result = 0xEE00 (-18.0).
4. Rounding: image[0] = 0x0001, filter[0] = 0x0080, all other elements 0 → result = 0x0001 (half rounds up). Same with filter[0] = 0xFF80 → result = 0x0000.
5. Backpressure: hold out_ready = 0 for 10 cycles after out_valid → result and out_valid stay stable and in_ready = 0. A second job offered with in_valid = 1 is accepted only on the cycle after out_ready = 1. Repeat with LANES = 1 (latency 19) and LANES = 18 (latency 2), which give identical results.
6. Assert reset mid-MAC (step 3) → out_valid, result and busy go to 0 immediately. After release, a fresh job produces the correct value, with no residue from the aborted accumulation.
